// File: rtl/log_argmax_pkg.sv
// Shared parameters for the nonlinear datapath: the log stage and the argmax
// stage both size their frames from these values.
package log_argmax_pkg;

    localparam int LA_DATA_WIDTH = 16;    // log-domain sample width
    localparam int LA_IDX_WIDTH  = 13;    // in-frame beat index width
    localparam int MEM_LEN       = 8192;  // LUT depth = maximum frame length

    // Frame tracking states; the result register is kept outside the FSM
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,  // no open frame
        ST_ACCUM = 1'b1   // frame open, running max valid
    } la_state_t;

endpackage

// File: rtl/log_argmax_cmp.sv
// Value/index compare-select for the running argmax. The candidate only wins
// on a strictly greater value, so ties keep the earliest index.
module argmax_cmp
    import log_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH,
    parameter int IDX_WIDTH  = LA_IDX_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] cur_max,
    input  logic [IDX_WIDTH-1:0]  cur_idx,
    input  logic [DATA_WIDTH-1:0] new_val,
    input  logic [IDX_WIDTH-1:0]  new_idx,
    output logic [DATA_WIDTH-1:0] sel_max,
    output logic [IDX_WIDTH-1:0]  sel_idx,
    output logic                  take_new
);

    // Unsigned strict-greater select
    always_comb begin
        take_new = (new_val > cur_max);
        sel_max  = cur_max;
        sel_idx  = cur_idx;
        if (take_new) begin
            sel_max = new_val;
            sel_idx = new_idx;
        end
    end

endmodule

// File: rtl/log_argmax.sv
// Streaming argmax over framed log-domain samples. Every valid beat is
// consumed (no backpressure); one result strobe per frame, one cycle after
// the tlast beat.
module log_argmax
    import log_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH,
    parameter int IDX_WIDTH  = LA_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    input  logic                  input_tlast,
    output logic [IDX_WIDTH-1:0]  output_tdata,
    output logic [DATA_WIDTH-1:0] output_tmax,
    output logic                  output_tvalid,
    output logic                  output_tlast,
    output logic                  overflow
);

    localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;

    la_state_t             state_q, state_d;
    logic [IDX_WIDTH-1:0]  cnt_q;
    logic [IDX_WIDTH-1:0]  run_idx_q;
    logic [DATA_WIDTH-1:0] run_max_q;

    logic [DATA_WIDTH-1:0] sel_max;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic                  take_new;
    logic [DATA_WIDTH-1:0] nxt_max;
    logic [IDX_WIDTH-1:0]  nxt_idx;
    logic                  idle;
    logic                  cnt_sat;
    logic                  last_beat;

    assign idle      = (state_q == ST_IDLE);
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign last_beat = input_tvalid && input_tlast;

    // Counter doubles as the candidate index; once saturated the index clamps
    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .cur_max  (run_max_q),
        .cur_idx  (run_idx_q),
        .new_val  (input_tdata),
        .new_idx  (cnt_q),
        .sel_max  (sel_max),
        .sel_idx  (sel_idx),
        .take_new (take_new)
    );

    // First beat of a frame seeds the running max regardless of its value
    always_comb begin
        nxt_max = sel_max;
        nxt_idx = sel_idx;
        if (idle) begin
            nxt_max = input_tdata;
            nxt_idx = '0;
        end
    end

    // Frame-open tracking; a 1-beat frame never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (input_tvalid && !input_tlast) state_d = ST_ACCUM;
            ST_ACCUM: if (last_beat)                    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Running max/index and beat counter; idle cycles hold everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            run_idx_q <= '0;
            run_max_q <= '0;
            overflow  <= 1'b0;
        end else if (input_tvalid) begin
            run_max_q <= nxt_max;
            run_idx_q <= nxt_idx;
            if (input_tlast) begin
                cnt_q <= '0;
            end else if (idle) begin
                cnt_q <= {{(IDX_WIDTH-1){1'b0}}, 1'b1};
            end else if (!cnt_sat) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                // Non-final beat with no index left: frame is too long
                overflow <= 1'b1;
            end
        end
    end

    // Result register: data holds between frames, only the strobe pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_tdata  <= '0;
            output_tmax   <= '0;
            output_tvalid <= 1'b0;
        end else begin
            output_tvalid <= last_beat;
            if (last_beat) begin
                output_tdata <= nxt_idx;
                output_tmax  <= nxt_max;
            end
        end
    end

    assign output_tlast = output_tvalid;

endmodule

// File: tb/tb_log_argmax.sv
module tb_log_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] input_tdata = '0;
    logic        input_tvalid = 1'b0;
    logic        input_tlast = 1'b0;
    logic [12:0] output_tdata;
    logic [15:0] output_tmax;
    logic        output_tvalid;
    logic        output_tlast;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    int snap;

    always #5 clk = ~clk;

    log_argmax dut (
        .clk           (clk),
        .rst           (rst),
        .input_tdata   (input_tdata),
        .input_tvalid  (input_tvalid),
        .input_tlast   (input_tlast),
        .output_tdata  (output_tdata),
        .output_tmax   (output_tmax),
        .output_tvalid (output_tvalid),
        .output_tlast  (output_tlast),
        .overflow      (overflow)
    );

    // Strobe counter sampled away from the active edge
    always @(negedge clk) if (rst && output_tvalid) n_strobe++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One beat, sampled on the next rising edge; returns 1 time unit later
    task automatic send(input logic [15:0] d, input logic l);
        input_tdata  = d;
        input_tvalid = 1'b1;
        input_tlast  = l;
        @(posedge clk); #1;
        input_tvalid = 1'b0;
        input_tlast  = 1'b0;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_res(input string tag, input logic [12:0] idx, input logic [15:0] mx);
        chk({tag, "_vld"},  {31'd0, output_tvalid}, 32'd1);
        chk({tag, "_last"}, {31'd0, output_tlast},  32'd1);
        chk({tag, "_idx"},  {19'd0, output_tdata},  {19'd0, idx});
        chk({tag, "_max"},  {16'd0, output_tmax},   {16'd0, mx});
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_vld", {31'd0, output_tvalid}, 32'd0);
        chk("rst_idx", {19'd0, output_tdata}, 32'd0);
        chk("rst_max", {16'd0, output_tmax}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        idle_cyc(2);

        // {5,9,3,9}: tie at 9 keeps the earlier index
        send(16'd5, 1'b0);
        send(16'd9, 1'b0);
        chk("mid_novld", {31'd0, output_tvalid}, 32'd0);
        send(16'd3, 1'b0);
        send(16'd9, 1'b1);
        chk_res("tie", 13'd1, 16'd9);
        idle_cyc(1);
        chk("tie_pulse", {31'd0, output_tvalid}, 32'd0);
        chk("tie_hold_max", {16'd0, output_tmax}, 32'd9);

        // Single-beat frame, then confirm IDLE by a fresh frame
        send(16'h00A0, 1'b1);
        chk_res("one", 13'd0, 16'h00A0);
        idle_cyc(1);

        // Back-to-back frames with no gap
        send(16'd1, 1'b0);
        send(16'd7, 1'b1);
        chk_res("b2b_a", 13'd1, 16'd7);
        send(16'hFFFF, 1'b0);
        send(16'd2, 1'b1);
        chk_res("b2b_b", 13'd0, 16'hFFFF);
        idle_cyc(1);

        // Gaps mid-frame, including a stray tlast without tvalid
        send(16'd4, 1'b0);
        idle_cyc(3);
        send(16'd8, 1'b0);
        snap = n_strobe;
        input_tlast = 1'b1;
        idle_cyc(1);
        input_tlast = 1'b0;
        idle_cyc(1);
        chk("gap_no_stray", n_strobe - snap, 32'd0);
        send(16'd2, 1'b1);
        chk_res("gap", 13'd1, 16'd8);
        idle_cyc(1);

        // Reset mid-frame discards the open frame
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        rst = 1'b0;
        #2;
        chk("arst_max", {16'd0, output_tmax}, 32'd0);
        chk("arst_idx", {19'd0, output_tdata}, 32'd0);
        idle_cyc(1);
        rst = 1'b1;
        snap = n_strobe;
        idle_cyc(1);
        send(16'd3, 1'b0);
        send(16'd6, 1'b1);
        chk_res("post_rst", 13'd1, 16'd6);
        idle_cyc(2);
        chk("post_rst_cnt", n_strobe - snap, 32'd1);

        // Long frame: 8191 beats legal, 8193 overflows
        for (int i = 0; i < 8191; i++) send((i == 100) ? 16'd50 : 16'd0, 1'b0);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        send(16'd0, 1'b0);
        send(16'd0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        send(16'd0, 1'b1);
        chk_res("ovf_frame", 13'd100, 16'd50);
        send(16'd2, 1'b0);
        send(16'd5, 1'b1);
        chk_res("ovf_next", 13'd1, 16'd5);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        idle_cyc(3);
        chk("ovf_sticky2", {31'd0, overflow}, 32'd1);
        rst = 1'b0;
        #2;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        idle_cyc(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/log_argmax.md
LOG_ARGMAX -- requirements
Module: log_argmax

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16: width of the log-domain sample consumed from the log stage.
REQ-002 The block SHALL expose parameter IDX_WIDTH, default 13: width of the in-frame beat index (max frame length 8192 = LUT depth).
REQ-003 The block SHALL expose port clk  input  1  sole clock, all state rising-edge.
REQ-004 The block SHALL expose port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL expose port input_tdata  input  DATA_WIDTH  unsigned log-domain sample.
REQ-006 The block SHALL expose port input_tvalid  input  1  beat qualifier; no ready, so every valid beat is consumed.
REQ-007 The block SHALL expose port input_tlast  input  1  marks the final beat of a frame; meaningful only with input_tvalid.
REQ-008 The block SHALL expose port output_tdata  output  IDX_WIDTH  index of the frame maximum.
REQ-009 The block SHALL expose port output_tmax  output  DATA_WIDTH  value of the frame maximum.
REQ-010 The block SHALL expose port output_tvalid  output  1  single-cycle result strobe, one per frame.
REQ-011 The block SHALL expose port output_tlast  output  1  equal to output_tvalid (one-beat result frame).
REQ-012 The block SHALL expose port overflow  output  1  sticky error: a frame exceeded 2^IDX_WIDTH beats.

Function
REQ-013 States SHALL be IDLE (no open frame) and ACCUM (frame open); the result register is separate from the state.
REQ-014 IDLE + valid beat without tlast -> ACCUM; running max = beat value, running index = 0, beat counter = 1.
REQ-015 IDLE + valid beat with tlast (1-beat frame) -> stays IDLE; result = {index 0, beat value}.
REQ-016 ACCUM + valid beat: replace running max/index only when beat value is strictly greater (unsigned); ties keep the earliest index.
REQ-017 ACCUM + valid beat with tlast -> IDLE; result is computed from the running max including that beat.
REQ-018 Result latency SHALL be exactly 1 cycle: output_tvalid=1 in the cycle after the tlast beat is sampled, and 0 otherwise.
REQ-019 Result output_tdata/output_tmax SHALL hold their last value until the next result; only output_tvalid and output_tlast pulse.
REQ-020 Back-to-back frames: the beat immediately after a tlast beat SHALL open a new frame with no bubble, even while the previous result is strobing.
REQ-021 Cycles with input_tvalid=0 SHALL leave all frame state unchanged (gaps allowed mid-frame).
REQ-022 Beat counter SHALL saturate at 2^IDX_WIDTH-1; a valid non-tlast beat arriving at saturation SHALL set overflow and SHALL NOT update the running index (value compare still applies, index clamps to saturated count).
REQ-023 overflow SHALL clear only on reset.
REQ-024 input_tlast with input_tvalid=0 SHALL be ignored.

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, counter=0, running max/index=0, output_tdata=0, output_tmax=0, output_tvalid=0, output_tlast=0, overflow=0.
REQ-026 Reset mid-frame SHALL discard the open frame; no result strobe for it after release.
REQ-027 The first valid beat after reset release SHALL be treated as the start of a frame.

Structure
REQ-028 DATA_WIDTH/IDX_WIDTH defaults and the MEM_LEN=8192 frame-depth constant SHALL live in the shared nonlinear-datapath parameter include, shared with the log stage.
REQ-029 One combinational sub-module, argmax_cmp (value/index compare-select, strict-greater), is natural; FSM, counter and result register stay in log_argmax.

Verification
REQ-030 Frame {5,9,3,9} with tlast on 4th beat -> one strobe next cycle: output_tdata=1, output_tmax=9.
REQ-031 Single-beat frame 0x00A0 with tlast -> strobe: index 0, max 0x00A0; state back to IDLE.
REQ-032 Back-to-back frames {1,7} and {0xFFFF,2}, no gaps -> strobes on consecutive frames: (1,7) then (0,0xFFFF), no lost beat.
REQ-033 Frame {4, gap 3 cycles, 8, gap, 2+tlast} -> index 1, max 8; gaps ignored.
REQ-034 Assert rst=0 after 2 beats of a frame, release, send {3,6+tlast} -> only one strobe: index 1, max 6.
REQ-035 Send 8193 beats without tlast (IDX_WIDTH=13) -> overflow=1 and stays 1 through subsequent frames until reset.
